// File: rtl/hi_arbiter_rr.sv
// rtl/hi_arbiter_rr.sv - multi-master HI device bus arbiter with read-request replay and lock timeout
// Grant decision is registered; bus and return muxing are combinational from the registered owner.
module hi_arbiter_rr #(
  parameter int NUM_HOSTS    = 2,
  parameter int RR_MODE      = 1,
  parameter int LOCK_TIMEOUT = 0,
  parameter int HOST_W       = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1
) (
  input  logic                      ifclk,
  input  logic                      reset,
  input  logic [16*NUM_HOSTS-1:0]   I_di_term_addr,
  input  logic [32*NUM_HOSTS-1:0]   I_di_reg_addr,
  input  logic [32*NUM_HOSTS-1:0]   I_di_len,
  input  logic [32*NUM_HOSTS-1:0]   I_di_reg_datai,
  input  logic [NUM_HOSTS-1:0]      I_di_write,
  input  logic [NUM_HOSTS-1:0]      I_di_write_mode,
  input  logic [NUM_HOSTS-1:0]      I_di_read_mode,
  input  logic [NUM_HOSTS-1:0]      I_di_read_req,
  input  logic [NUM_HOSTS-1:0]      I_di_read,
  input  logic [NUM_HOSTS-1:0]      I_lock_arbitor,
  output logic [NUM_HOSTS-1:0]      O_di_write_rdy,
  output logic [NUM_HOSTS-1:0]      O_di_read_rdy,
  output logic [32*NUM_HOSTS-1:0]   O_di_reg_datao,
  output logic [16*NUM_HOSTS-1:0]   O_di_transfer_status,
  output logic [15:0]               di_term_addr,
  output logic [31:0]               di_reg_addr,
  output logic [31:0]               di_len,
  output logic [31:0]               di_reg_datai,
  output logic                      di_read_mode,
  output logic                      di_read_req,
  output logic                      di_read,
  output logic                      di_write,
  output logic                      di_write_mode,
  input  logic                      di_read_rdy,
  input  logic                      di_write_rdy,
  input  logic [31:0]               di_reg_datao,
  input  logic [15:0]               di_transfer_status,
  output logic [HOST_W-1:0]         owner,
  output logic                      owner_valid,
  output logic                      lock_timeout
);

  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t               state, state_nxt;
  logic [HOST_W-1:0]    owner_nxt, last_owner, last_owner_nxt;
  logic [HOST_W-1:0]    win_all, win_oth;
  logic [NUM_HOSTS-1:0] pend, pend_nxt, req, sel, oth_mask;
  logic [CNT_W-1:0]     lock_cnt, lock_cnt_nxt;
  logic                 own_mode, own_lock, own_rreq, replay;
  logic                 any_req, oth_req, expired, busy, lock_idle, handover;

  // Round-robin ranks each requester by its distance after base; fixed priority by index.
  function automatic logic [HOST_W-1:0] pick(input logic [NUM_HOSTS-1:0] mask,
                                             input logic [HOST_W-1:0]    base);
    logic [HOST_W-1:0] w;
    int                best;
    int                d;
    w    = '0;
    best = NUM_HOSTS;
    for (int k = 0; k < NUM_HOSTS; k++) begin
      if (RR_MODE != 0)
        d = (k > int'(base)) ? (k - int'(base) - 1) : (k + NUM_HOSTS - int'(base) - 1);
      else
        d = k;
      if (mask[k] && (d < best)) begin
        best = d;
        w    = HOST_W'(k);
      end
    end
    return w;
  endfunction

  assign owner_valid = (state == ST_GRANT);

  always_comb begin
    sel      = '0;
    oth_mask = '0;
    for (int k = 0; k < NUM_HOSTS; k++) begin
      sel[k]      = owner_valid && (owner == HOST_W'(k));
      oth_mask[k] = (owner != HOST_W'(k));
    end
  end

  assign req       = I_di_read_mode | I_di_write_mode | pend;
  assign any_req   = |req;
  assign oth_req   = |(req & oth_mask);
  assign own_mode  = |(sel & (I_di_read_mode | I_di_write_mode));
  assign own_lock  = |(sel & I_lock_arbitor);
  assign own_rreq  = |(sel & I_di_read_req);
  // pend can only be set while a host is not owner, so pend[owner] is live only in its first grant cycle.
  assign replay    = |(sel & pend);
  assign lock_idle = own_lock & ~own_mode;
  assign expired   = (LOCK_TIMEOUT != 0) && (lock_cnt == CNT_MAX) && oth_req;
  assign busy      = own_mode | (own_lock & ~expired);
  assign win_all   = pick(req, last_owner);
  assign win_oth   = pick(req & oth_mask, last_owner);

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    handover       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt      = ST_GRANT;
          owner_nxt      = win_all;
          last_owner_nxt = win_all;
        end
      end
      ST_GRANT: begin
        if (!busy) begin
          if (oth_req) begin
            owner_nxt      = win_oth;
            last_owner_nxt = win_oth;
            handover       = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_nxt     = (pend | I_di_read_req) & ~sel;
    lock_cnt_nxt = '0;
    if (lock_idle && !handover)
      lock_cnt_nxt = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      state        <= ST_IDLE;
      owner        <= '0;
      last_owner   <= HOST_W'(NUM_HOSTS - 1);
      pend         <= '0;
      lock_cnt     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      last_owner   <= last_owner_nxt;
      pend         <= pend_nxt;
      lock_cnt     <= lock_cnt_nxt;
      lock_timeout <= handover & expired;
    end
  end

  always_comb begin
    di_term_addr  = '0;
    di_reg_addr   = '0;
    di_len        = '0;
    di_reg_datai  = '0;
    di_read_mode  = 1'b0;
    di_read       = 1'b0;
    di_write      = 1'b0;
    di_write_mode = 1'b0;
    for (int k = 0; k < NUM_HOSTS; k++) begin
      if (sel[k]) begin
        di_term_addr  = I_di_term_addr[16*k +: 16];
        di_reg_addr   = I_di_reg_addr[32*k +: 32];
        di_len        = I_di_len[32*k +: 32];
        di_reg_datai  = I_di_reg_datai[32*k +: 32];
        di_read_mode  = I_di_read_mode[k];
        di_read       = I_di_read[k];
        di_write      = I_di_write[k];
        di_write_mode = I_di_write_mode[k];
      end
    end
  end

  assign di_read_req = own_rreq | replay;

  always_comb begin
    O_di_write_rdy       = '0;
    O_di_read_rdy        = '0;
    O_di_reg_datao       = '0;
    O_di_transfer_status = '0;
    for (int k = 0; k < NUM_HOSTS; k++) begin
      if (sel[k]) begin
        O_di_write_rdy[k]                 = di_write_rdy;
        O_di_read_rdy[k]                  = di_read_rdy;
        O_di_reg_datao[32*k +: 32]        = di_reg_datao;
        O_di_transfer_status[16*k +: 16]  = di_transfer_status;
      end
    end
  end

endmodule

// File: tb/tb_hi_arbiter_rr.sv
// tb/tb_hi_arbiter_rr.sv - directed scoreboard bench for hi_arbiter_rr (RR/timeout and fixed/no-timeout instances)
module tb_hi_arbiter_rr;
  localparam int N = 3;

  logic ifclk = 1'b0;
  logic reset = 1'b1;
  always #5 ifclk = ~ifclk;

  logic [16*N-1:0] term;
  logic [32*N-1:0] raddr, len, datai;
  logic [N-1:0]    wr, wmode, rmode, rreq, rd, lock;
  logic            rrdy, wrdy;
  logic [31:0]     dout;
  logic [15:0]     tstat;

  logic [N-1:0]    a_wrdy_o, a_rrdy_o, b_wrdy_o, b_rrdy_o;
  logic [32*N-1:0] a_datao, b_datao;
  logic [16*N-1:0] a_tstat, b_tstat;
  logic [15:0]     a_term, b_term;
  logic [31:0]     a_raddr, a_len, a_datai, b_raddr, b_len, b_datai;
  logic            a_rmode, a_rreq, a_rd, a_wr, a_wmode, a_valid, a_lto;
  logic            b_rmode, b_rreq, b_rd, b_wr, b_wmode, b_valid, b_lto;
  logic [1:0]      a_owner, b_owner;

  hi_arbiter_rr #(.NUM_HOSTS(N), .RR_MODE(1), .LOCK_TIMEOUT(5)) dut_a (
    .ifclk(ifclk), .reset(reset),
    .I_di_term_addr(term), .I_di_reg_addr(raddr), .I_di_len(len), .I_di_reg_datai(datai),
    .I_di_write(wr), .I_di_write_mode(wmode), .I_di_read_mode(rmode), .I_di_read_req(rreq),
    .I_di_read(rd), .I_lock_arbitor(lock),
    .O_di_write_rdy(a_wrdy_o), .O_di_read_rdy(a_rrdy_o), .O_di_reg_datao(a_datao),
    .O_di_transfer_status(a_tstat),
    .di_term_addr(a_term), .di_reg_addr(a_raddr), .di_len(a_len), .di_reg_datai(a_datai),
    .di_read_mode(a_rmode), .di_read_req(a_rreq), .di_read(a_rd), .di_write(a_wr),
    .di_write_mode(a_wmode),
    .di_read_rdy(rrdy), .di_write_rdy(wrdy), .di_reg_datao(dout), .di_transfer_status(tstat),
    .owner(a_owner), .owner_valid(a_valid), .lock_timeout(a_lto)
  );

  hi_arbiter_rr #(.NUM_HOSTS(N), .RR_MODE(0), .LOCK_TIMEOUT(0)) dut_b (
    .ifclk(ifclk), .reset(reset),
    .I_di_term_addr(term), .I_di_reg_addr(raddr), .I_di_len(len), .I_di_reg_datai(datai),
    .I_di_write(wr), .I_di_write_mode(wmode), .I_di_read_mode(rmode), .I_di_read_req(rreq),
    .I_di_read(rd), .I_lock_arbitor(lock),
    .O_di_write_rdy(b_wrdy_o), .O_di_read_rdy(b_rrdy_o), .O_di_reg_datao(b_datao),
    .O_di_transfer_status(b_tstat),
    .di_term_addr(b_term), .di_reg_addr(b_raddr), .di_len(b_len), .di_reg_datai(b_datai),
    .di_read_mode(b_rmode), .di_read_req(b_rreq), .di_read(b_rd), .di_write(b_wr),
    .di_write_mode(b_wmode),
    .di_read_rdy(rrdy), .di_write_rdy(wrdy), .di_reg_datao(dout), .di_transfer_status(tstat),
    .owner(b_owner), .owner_valid(b_valid), .lock_timeout(b_lto)
  );

  int   errors = 0;
  int   checks = 0;
  int   qa[$];
  int   qb[$];
  logic mon_b = 1'b1;
  logic pv_a = 1'b0, pv_b = 1'b0;
  logic [1:0] po_a = '0, po_b = '0;
  int   idle_cnt;
  int   bad_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; every new grant seen on either DUT is matched against its scoreboard.
  task automatic cyc();
    int e;
    @(posedge ifclk);
    #1;
    if (a_valid && (!pv_a || a_owner != po_a)) begin
      e = (qa.size() > 0) ? qa.pop_front() : 9;
      chk("grant_a", a_owner, e);
    end
    if (mon_b && b_valid && (!pv_b || b_owner != po_b)) begin
      e = (qb.size() > 0) ? qb.pop_front() : 9;
      chk("grant_b", b_owner, e);
    end
    pv_a = a_valid; po_a = a_owner;
    pv_b = b_valid; po_b = b_owner;
  endtask

  initial begin
    term  = {16'hA002, 16'hA001, 16'hA000};
    raddr = {32'h2000_0002, 32'h1000_0001, 32'h0000_0100};
    len   = {32'd30, 32'd20, 32'd10};
    datai = {32'hC2, 32'hC1, 32'hC0};
    wr = '0; wmode = '0; rmode = '0; rreq = '0; rd = '0; lock = '0;
    rrdy = 1'b1; wrdy = 1'b1; dout = 32'hDEAD_BEEF; tstat = 16'h1234;

    // reset held with host 1 requesting
    reset = 1'b1; wmode = 3'b010; wr = 3'b010;
    repeat (3) begin
      cyc();
      chk("rst_valid_a", a_valid, 0);
      chk("rst_owner_a", a_owner, 0);
      chk("rst_bus_a", {a_term, a_wr, a_wmode, a_raddr}, 0);
      chk("rst_ret_a", {a_wrdy_o, a_rrdy_o, a_datao, a_tstat}, 0);
      chk("rst_valid_b", b_valid, 0);
      chk("rst_lto_a", a_lto, 0);
    end
    qa.push_back(1); qb.push_back(1);
    reset = 1'b0;
    cyc();
    chk("rel_valid_a", a_valid, 1);
    chk("rel_term_a", a_term, 16'hA001);
    chk("rel_raddr_a", a_raddr, 32'h1000_0001);
    chk("rel_wr_a", a_wr, 1);
    chk("rel_wrdy_a", a_wrdy_o, 3'b010);
    chk("rel_datao_a", a_datao, {32'h0, 32'hDEAD_BEEF, 32'h0});
    chk("rel_tstat_b", b_tstat, {16'h0, 16'h1234, 16'h0});
    wmode = '0; wr = '0;
    cyc();
    chk("rel_idle_a", a_valid, 0);
    chk("rel_keep_owner_a", a_owner, 1);
    chk("rel_idle_bus_a", a_term, 0);

    // round-robin on dut_a: fresh reset so host 0 goes first
    mon_b = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rmode = 3'b111;
    qa.push_back(0); qa.push_back(1); qa.push_back(2); qa.push_back(0);
    cyc();
    idle_cnt = 0;
    for (int h = 0; h < 3; h++) begin
      repeat (3) begin
        cyc();
        if (!a_valid) idle_cnt++;
      end
      rmode[h] = 1'b0;
      if (h == 1) rmode[0] = 1'b1;
      cyc();
      if (!a_valid) idle_cnt++;
    end
    chk("rr_idle_cycles", idle_cnt, 0);
    chk("rr_last_owner", a_owner, 0);
    chk("rr_queue", qa.size(), 0);
    rmode = '0;
    cyc();
    chk("rr_release", a_valid, 0);

    // fixed priority vs round-robin after host 1 releases
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mon_b = 1'b1;
    qa.push_back(1); qb.push_back(1);
    wmode = 3'b010;
    cyc();
    wmode[0] = 1'b1; rmode[2] = 1'b1;
    cyc();
    qa.push_back(2); qb.push_back(0);
    wmode[1] = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      wr[0] = i[0];
      #1;
      chk("fp_owner_b", b_owner, 0);
      chk("fp_write_b", b_wr, wr[0]);
      chk("fp_h2_rdy_b", b_rrdy_o, 3'b001);
      cyc();
    end
    chk("fp_owner_a", a_owner, 2);
    wr = '0; wmode = '0; rmode = '0;
    cyc();
    chk("fp_idle_b", b_valid, 0);

    // read-request replay
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    qa.push_back(0); qb.push_back(0);
    wmode[0] = 1'b1;
    cyc();
    rreq[1] = 1'b1;
    #1;
    chk("rp_no_pass_a", a_rreq, 0);
    cyc();
    rreq[1] = 1'b0;
    chk("rp_pend_set_a", dut_a.pend[1], 1);
    cyc();
    cyc();
    chk("rp_hold_a", a_owner, 0);
    qa.push_back(1); qb.push_back(1);
    wmode[0] = 1'b0;
    cyc();
    chk("rp_replay_a", a_rreq, 1);
    chk("rp_replay_b", b_rreq, 1);
    chk("rp_rdy_a", a_rrdy_o, 3'b010);
    cyc();
    chk("rp_done_valid_a", a_valid, 0);
    chk("rp_done_rreq_a", a_rreq, 0);
    chk("rp_pend_clr_a", dut_a.pend[1], 0);
    chk("rp_pend_clr_b", dut_b.pend[1], 0);

    // read_req arriving in the same cycle as the grant
    qa.push_back(2); qb.push_back(2);
    wmode[2] = 1'b1; rreq[2] = 1'b1;
    cyc();
    rreq[2] = 1'b0;
    #1;
    chk("rp_same_a", a_rreq, 1);
    cyc();
    chk("rp_once_a", a_rreq, 0);
    chk("rp_once_owner_a", a_owner, 2);
    wmode = '0;
    cyc();

    // idle lock: dut_a times out after 5 cycles, dut_b holds indefinitely
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    qa.push_back(0); qb.push_back(0);
    wmode[0] = 1'b1; lock[0] = 1'b1;
    cyc();
    qa.push_back(1);
    wmode[0] = 1'b0; rmode[1] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("lt_hold_a", a_owner, 0);
      chk("lt_nopulse_a", a_lto, 0);
    end
    cyc();
    chk("lt_handover_a", a_owner, 1);
    chk("lt_pulse_a", a_lto, 1);
    cyc();
    chk("lt_pulse_end_a", a_lto, 0);
    bad_cnt = 0;
    repeat (100) begin
      cyc();
      if (!b_valid || b_owner != 2'd0 || b_lto) bad_cnt++;
    end
    chk("nt_hold_b", bad_cnt, 0);
    chk("nt_owner_a", a_owner, 1);

    // reset mid-transfer drops pending replays
    rreq[2] = 1'b1;
    cyc();
    rreq[2] = 1'b0;
    chk("mr_pend_set_b", dut_b.pend[2], 1);
    reset = 1'b1;
    cyc();
    chk("mr_valid_a", a_valid, 0);
    chk("mr_valid_b", b_valid, 0);
    chk("mr_pend_b", dut_b.pend, 0);
    chk("mr_rmode_a", a_rmode, 0);
    reset = 1'b0; rmode = '0; lock = '0;
    cyc();
    cyc();
    chk("mr_no_replay_a", a_valid, 0);
    chk("mr_no_replay_b", b_valid, 0);
    chk("sb_empty_a", qa.size(), 0);
    chk("sb_empty_b", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hi_arbiter_rr.md
# hi_arbiter_rr

Registered, parametrised multi-master arbiter for the Host Interface (HI) device bus. It sits between NUM_HOSTS HI masters and a single shared HI device bus. It adds round-robin or fixed-priority selection, replay of read requests issued out of turn, and a lock-hold timeout so a stalled master cannot starve the others. Bus muxing stays combinational from a registered owner; only the grant decision is sequential.

## Interface
Parameters:
- NUM_HOSTS, 2: number of masters, ≥1.
- RR_MODE, 1: 1 = round-robin starting after the last owner; 0 = fixed priority, lowest index wins.
- LOCK_TIMEOUT, 0: idle-lock cycles before a forced release; 0 disables the timeout.
- HOST_W, (NUM_HOSTS>1 ? $clog2(NUM_HOSTS) : 1): owner index width (derived).

Ports:
- ifclk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- I_di_term_addr  in  16*NUM_HOSTS  packed per-host term addr; host k is at [16k+15:16k]. Same packing rule applies to every packed port below.
- I_di_reg_addr, I_di_len, I_di_reg_datai  in  32*NUM_HOSTS  packed per-host fields.
- I_di_write, I_di_write_mode, I_di_read_mode, I_di_read_req, I_di_read, I_lock_arbitor  in  NUM_HOSTS  per-host strobes and modes.
- O_di_write_rdy, O_di_read_rdy  out  NUM_HOSTS  per-host ready.
- O_di_reg_datao  out  32*NUM_HOSTS  per-host read data.
- O_di_transfer_status  out  16*NUM_HOSTS  per-host transfer status.
- di_term_addr 16, di_reg_addr 32, di_len 32, di_reg_datai 32, di_read_mode, di_read_req, di_read, di_write, di_write_mode  out  shared bus to devices.
- di_read_rdy, di_write_rdy  in  1; di_reg_datao  in  32; di_transfer_status  in  16: shared device returns.
- owner  out  HOST_W  current owner index.
- owner_valid  out  1  an owner holds the bus.
- lock_timeout  out  1  one-cycle pulse on a forced release.

## Operation
- Definitions:
  - req[k] = I_di_read_mode[k] | I_di_write_mode[k] | pend[k].
  - busy = owner's read_mode | write_mode | (lock & !expired).
- When owner_valid=1: all shared outputs mux from host `owner`. di_read_req = I_di_read_req[owner] | replay.
- Return path: only the owner sees di_read_rdy, di_write_rdy, di_reg_datao and di_transfer_status. Every other host sees 0.
- When owner_valid=0: all shared outputs and all O_* outputs are 0.
- States:
  - IDLE (owner_valid=0): if any req, select a winner and go to GRANT with owner <= winner.
  - GRANT, owner busy: stay.
  - GRANT, !busy, some other host requests: owner <= winner over the other hosts; stay in GRANT.
  - GRANT, !busy, no other host requests: go to IDLE. Owner keeps its value.
- Winner selection:
  - RR_MODE=1: first requester searching last_owner+1, +2, … modulo NUM_HOSTS.
  - RR_MODE=0: lowest requesting index.
- Pending read_req:
  - pend[k] <= 1 when I_di_read_req[k]=1 and host k is not the current valid owner.
  - Issued as replay for exactly one cycle, the first GRANT cycle for host k. pend[k] clears in that same cycle.
  - If I_di_read_req[k] rises in the same cycle k is being granted, pend[k] sets and replays in the next cycle.
- Lock timeout:
  - lock_cnt increments while the owner has lock=1 and read_mode=0 and write_mode=0. Otherwise it clears.
  - expired = (LOCK_TIMEOUT!=0) & (lock_cnt==LOCK_TIMEOUT) & (some other host requests).
  - When expired causes a handover, lock_timeout pulses 1 for one cycle and lock_cnt clears.
  - lock_cnt saturates at LOCK_TIMEOUT and is $clog2(LOCK_TIMEOUT+1) bits wide.
- NUM_HOSTS=1: owner is fixed at 0. Arbitration degenerates to IDLE/GRANT tracking.

## Timing
- Reset values: owner=0, owner_valid=0, last_owner=NUM_HOSTS-1 (host 0 is first under RR), pend=0, lock_cnt=0, lock_timeout=0.
  - All shared outputs and all per-host outputs are 0 during reset.
- Reset asserted mid-transfer: every register returns to its reset value at the next edge. Pending replays are dropped.
- Grant latency: a request in IDLE at edge N gives owner_valid=1 after edge N+1. Bus muxing follows the owner in the same cycle.
- Handover: the owner drops busy in cycle N; the new owner drives the bus from cycle N+1. No IDLE cycle is inserted.
- Handshake: ready and data pass through combinationally. The arbiter adds no latency inside a transfer and never switches owner while busy=1.

## Test plan
- Reset:
  - Stimulus: hold reset 3 cycles with host 1 write_mode=1.
  - Required: all outputs 0 and owner_valid=0.
  - Then release reset: owner=1 and owner_valid=1 one cycle later.
- Round-robin (NUM_HOSTS=3, RR_MODE=1):
  - Stimulus: all hosts hold read_mode for 4 cycles each, then drop it, then re-request.
  - Required: grant order 0,1,2,0. Each handover has zero idle cycles.
- Fixed priority (RR_MODE=0):
  - Stimulus: hosts 0 and 2 request continuously with short transfers.
  - Required: host 0 always wins and host 2 is never granted.
- Read-request replay:
  - Stimulus: host 1 pulses read_req while host 0 is the owner.
  - Required: once host 0 releases, di_read_req=1 for exactly one cycle in host 1's first grant cycle. pend[1] then reads 0.
- Lock timeout (LOCK_TIMEOUT=5):
  - Stimulus: host 0 holds lock with no mode; host 1 requests.
  - Required: handover to host 1 after 5 idle-lock cycles, with a single-cycle lock_timeout pulse.
  - Same stimulus with LOCK_TIMEOUT=0: host 0 keeps the bus for 100 cycles.
